// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and
// instruction memory.
//   req_valid  fetch request valid (fetch unit -> memory)
//   req_ready  memory accepts the request (memory -> fetch unit)
//   addr       fetch address (fetch unit -> memory)
//   rsp_valid  fetched data returned, one-cycle pulse (memory -> fetch unit)
//   rsp_data   fetched instruction (memory -> fetch unit)
interface pc_fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] addr;
  logic        rsp_valid;
  logic [15:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage of the 16-bit CPU.
// Issues one fetch at a time over the imem channel and holds the returned
// instruction in a one-entry buffer for decode.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   redirect       taken branch/jump this cycle, load next_pc
//   next_pc        redirect target from the PC-source multiplexer
//   imem           instruction-memory channel (master side)
//   inst_valid     buffer holds an instruction for decode
//   inst, inst_pc  buffered instruction and its address
//   inst_pc_plus2  inst_pc + 2, sequential input of the PC-source mux
//   id_ready       decode consumes the buffer this cycle when inst_valid=1
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect,
  input  logic [15:0]             next_pc,
  pc_fetch_unit_if.master         imem,
  output logic                    inst_valid,
  output logic [15:0]             inst,
  output logic [15:0]             inst_pc,
  output logic [15:0]             inst_pc_plus2,
  input  logic                    id_ready
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;

  logic        req_valid;
  logic        handshake;
  logic        redirect_eff;
  logic        load;

  // Redirects are ignored while idle (only the cycle after reset release).
  assign redirect_eff = redirect && (state_q != StIdle);
  assign handshake    = req_valid && imem.req_ready;
  // A response that coincides with a redirect is stale and is discarded.
  assign load         = (state_q == StWait) && imem.rsp_valid && !redirect_eff;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (handshake) state_d = redirect_eff ? StDrop : StWait;
      end
      StWait: begin
        if (imem.rsp_valid)    state_d = StReq;
        else if (redirect_eff) state_d = StDrop;
      end
      StDrop: begin
        if (imem.rsp_valid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs. Requests are only issued when the buffer is free or being
  // consumed, so a response can always be written without skid storage.
  always_comb begin
    req_valid = 1'b0;
    if (state_q == StReq) req_valid = !inst_valid_q || id_ready;
  end

  assign imem.req_valid = req_valid;
  assign imem.addr      = pc_q;

  // Datapath next-state
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (handshake) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 16'd2;
    end
    if (redirect_eff) pc_d = next_pc;

    if (load) begin
      inst_d    = imem.rsp_data;
      inst_pc_d = req_pc_q;
    end

    // Flush beats load beats consume.
    if (redirect_eff)                  inst_valid_d = 1'b0;
    else if (load)                     inst_valid_d = 1'b1;
    else if (inst_valid_q && id_ready) inst_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 16'h0000;
      inst_q       <= 16'h0000;
      inst_pc_q    <= 16'h0000;
      inst_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_pc_plus2 = inst_pc_q + 16'd2;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [15:0] next_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_plus2;

  int checks;
  int failures;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(
    .RESET_PC(16'h0100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .next_pc      (next_pc),
    .imem         (imem),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_pc_plus2(inst_pc_plus2),
    .id_ready     (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; next_pc = 16'h0000; id_ready = 1'b1;
    imem.req_ready = 1'b1; imem.rsp_valid = 1'b0; imem.rsp_data = 16'h0000;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    checks++; if (inst !== 16'h0000) begin failures++; $display("FAIL reset_inst got=%h want=0000", inst); end
    checks++; if (inst_pc !== 16'h0000) begin failures++; $display("FAIL reset_inst_pc got=%h want=0000", inst_pc); end
    checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", imem.req_valid); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential_fetch();
    tick();  // idle -> request
    checks++; if (imem.req_valid !== 1'b1) begin failures++; $display("FAIL seq_first_req got=%b want=1", imem.req_valid); end
    checks++; if (imem.addr !== 16'h0100) begin failures++; $display("FAIL seq_addr0 got=%h want=0100", imem.addr); end
    tick();  // handshake -> wait
    checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL seq_wait_req got=%b want=0", imem.req_valid); end
    imem.rsp_valid = 1'b1; imem.rsp_data = 16'hA001;
    tick();
    imem.rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL seq_valid0 got=%b want=1", inst_valid); end
    checks++; if (inst !== 16'hA001) begin failures++; $display("FAIL seq_inst0 got=%h want=A001", inst); end
    checks++; if (inst_pc !== 16'h0100) begin failures++; $display("FAIL seq_pc0 got=%h want=0100", inst_pc); end
    checks++; if (inst_pc_plus2 !== 16'h0102) begin failures++; $display("FAIL seq_pc2_0 got=%h want=0102", inst_pc_plus2); end
    checks++; if (imem.addr !== 16'h0102 || imem.req_valid !== 1'b1) begin failures++; $display("FAIL seq_addr1 got=%h/%b want=0102/1", imem.addr, imem.req_valid); end
    tick();  // handshake at 0x0102, buffer consumed
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL seq_consumed got=%b want=0", inst_valid); end
    imem.rsp_valid = 1'b1; imem.rsp_data = 16'hA002;
    tick();
    imem.rsp_valid = 1'b0;
    checks++; if (inst !== 16'hA002 || inst_valid !== 1'b1) begin failures++; $display("FAIL seq_inst1 got=%h/%b want=A002/1", inst, inst_valid); end
    checks++; if (inst_pc !== 16'h0102) begin failures++; $display("FAIL seq_pc1 got=%h want=0102", inst_pc); end
  endtask

  task automatic test_decode_stall();
    id_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%b want=0", i, imem.req_valid); end
      checks++; if (inst !== 16'hA002 || inst_valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got=%h/%b want=A002/1", i, inst, inst_valid); end
      tick();
    end
    id_ready = 1'b1;
    #1;
    checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 16'h0104) begin failures++; $display("FAIL stall_release got=%b/%h want=1/0104", imem.req_valid, imem.addr); end
  endtask

  task automatic test_redirect_in_wait();
    tick();  // handshake at 0x0104 -> wait
    checks++; if (imem.req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rdw_wait got=%b/%b want=0/0", imem.req_valid, inst_valid); end
    redirect = 1'b1; next_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    tick();  // still draining, no response yet
    checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL rdw_drop_req got=%b want=0", imem.req_valid); end
    imem.rsp_valid = 1'b1; imem.rsp_data = 16'hDEAD;
    tick();
    imem.rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdw_valid got=%b want=0", inst_valid); end
    checks++; if (inst === 16'hDEAD) begin failures++; $display("FAIL rdw_stale got=%h want=not DEAD", inst); end
    checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 16'h0200) begin failures++; $display("FAIL rdw_next got=%b/%h want=1/0200", imem.req_valid, imem.addr); end
  endtask

  task automatic test_redirect_on_handshake();
    // Redirect without handshake first: stays in request with new address.
    imem.req_ready = 1'b0; redirect = 1'b1; next_pc = 16'h0104;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 16'h0104) begin failures++; $display("FAIL rdh_noack got=%b/%h want=1/0104", imem.req_valid, imem.addr); end
    imem.req_ready = 1'b1; redirect = 1'b1; next_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL rdh_drop_req got=%b want=0", imem.req_valid); end
    imem.rsp_valid = 1'b1; imem.rsp_data = 16'h1111;
    tick();
    imem.rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdh_valid got=%b want=0", inst_valid); end
    checks++; if (imem.addr !== 16'h0200 || imem.req_valid !== 1'b1) begin failures++; $display("FAIL rdh_next got=%h/%b want=0200/1", imem.addr, imem.req_valid); end
  endtask

  task automatic test_pc_wrap();
    imem.req_ready = 1'b0; redirect = 1'b1; next_pc = 16'hFFFE;
    tick();
    redirect = 1'b0; imem.req_ready = 1'b1;
    #1;
    checks++; if (imem.addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_addr0 got=%h want=FFFE", imem.addr); end
    tick();
    imem.rsp_valid = 1'b1; imem.rsp_data = 16'hC001;
    tick();
    imem.rsp_valid = 1'b0;
    checks++; if (inst !== 16'hC001 || inst_pc !== 16'hFFFE) begin failures++; $display("FAIL wrap_inst0 got=%h@%h want=C001@FFFE", inst, inst_pc); end
    checks++; if (inst_pc_plus2 !== 16'h0000) begin failures++; $display("FAIL wrap_pc2 got=%h want=0000", inst_pc_plus2); end
    checks++; if (imem.addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr1 got=%h want=0000", imem.addr); end
    tick();
    imem.rsp_valid = 1'b1; imem.rsp_data = 16'hC002;
    tick();
    imem.rsp_valid = 1'b0;
    checks++; if (inst !== 16'hC002 || inst_pc !== 16'h0000 || inst_pc_plus2 !== 16'h0002) begin failures++; $display("FAIL wrap_inst1 got=%h@%h+%h want=C002@0000+0002", inst, inst_pc, inst_pc_plus2); end
  endtask

  task automatic test_reset_in_wait();
    tick();  // handshake at 0x0002 -> wait
    checks++; if (imem.req_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_req got=%b want=0", imem.req_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 16'h0000) begin failures++; $display("FAIL rst_async got=%b/%h want=0/0000", inst_valid, inst); end
    tick();
    // Late response and a redirect arrive while idle: both must be ignored.
    rst_n = 1'b1; imem.rsp_valid = 1'b1; imem.rsp_data = 16'hBAD1;
    redirect = 1'b1; next_pc = 16'h0500;
    tick();
    imem.rsp_valid = 1'b0; redirect = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_late_valid got=%b want=0", inst_valid); end
    checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 16'h0100) begin failures++; $display("FAIL rst_first_req got=%b/%h want=1/0100", imem.req_valid, imem.addr); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_after_valid got=%b want=0", inst_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential_fetch();
    test_decode_stall();
    test_redirect_in_wait();
    test_redirect_on_handshake();
    test_pc_wrap();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch stage of the 16-bit CPU; sits directly downstream of the PC-source multiplexer and consumes its selected next PC on taken branches/jumps.
- Issues one fetch at a time to instruction memory over a valid/ready request channel and collects the response.
- Holds the fetched instruction in a one-entry buffer for decode, with its PC and PC+2 (PC+2 feeds the multiplexer's sequential-address input).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect  input  1  taken branch/jump this cycle; load next_pc.
- next_pc  input  16  target from PC-source multiplexer; valid when redirect=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts request.
- imem_addr  output  16  fetch address.
- imem_rsp_valid  input  1  fetch data returned, one-cycle pulse.
- imem_rsp_data  input  16  fetched instruction.
- inst_valid  output  1  buffer holds an instruction for decode.
- inst  output  16  buffered instruction.
- inst_pc  output  16  address of buffered instruction.
- inst_pc_plus2  output  16  inst_pc + 2, to multiplexer sequential input.
- id_ready  input  1  decode consumes buffer this cycle when inst_valid=1.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_IDLE.
  - inst_valid=0, inst=0, inst_pc=0, imem_req_valid=0.
  - Any response returning after reset release is ignored, because rsp_valid is only sampled in S_WAIT/S_DROP.
- Arithmetic: all additions are 16-bit modulo; 16'hFFFE+2 = 16'h0000. inst_pc_plus2 is combinational from inst_pc.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_DROP. At most one request outstanding.
- S_IDLE:
  - imem_req_valid=0.
  - Go to S_REQ next cycle, so the first request is asserted on the 1st edge after reset release.
- S_REQ:
  - imem_req_valid = (!inst_valid || id_ready); imem_addr = pc.
  - On handshake (valid && ready): req_pc<=pc, pc<=pc+2, go to S_WAIT.
  - Holding valid without ready: imem_addr stays stable, valid is not withdrawn except by the id gating.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_pc<=req_pc, inst_valid<=1, go to S_REQ.
  - The buffer is guaranteed free here because requests are only issued when the buffer is empty or being consumed. No skid storage.
- S_DROP:
  - imem_req_valid=0.
  - On imem_rsp_valid: discard data, inst_valid unchanged, go to S_REQ.
- Consumption:
  - inst_valid && id_ready clears inst_valid next edge, unless a response loads it in the same edge (load wins).
- Redirect (any state except S_IDLE; highest priority):
  - pc<=next_pc; inst_valid<=0, which flushes the buffer even if id_ready=1.
  - S_REQ without handshake: stay in S_REQ, next request uses next_pc.
  - S_REQ with simultaneous handshake: handshake completes on the old address, pc<=next_pc (overrides +2), go to S_DROP.
  - S_WAIT, no rsp: go to S_DROP.
  - S_WAIT with simultaneous rsp: response discarded, go to S_REQ.
  - S_DROP: pc updated, remain in S_DROP until rsp.
- Redirect in S_IDLE: ignored.
- Throughput:
  - Back-to-back fetches with zero-wait memory (rsp one cycle after handshake) and id_ready=1 yield one instruction per 2 cycles.
  - Buffer is not refilled beyond one entry.

Test Plan:
- Reset release with RESET_PC=16'h0100, ready=1, 1-cycle rsp data 16'hA001, 16'hA002 -> imem_addr 0x0100 then 0x0102; inst 0xA001 with inst_pc 0x0100 and inst_pc_plus2 0x0102, then 0xA002 with inst_pc 0x0102.
- Decode stall: id_ready=0 while inst_valid=1 -> imem_req_valid stays 0, inst held stable. Raise id_ready -> request for next address issued in the same cycle.
- Redirect in S_WAIT to next_pc=0x0200, then stale rsp 0xDEAD -> 0xDEAD never appears on inst; next imem_addr is 0x0200.
- Redirect coincident with a request handshake at pc 0x0104 -> request accepted, its response is dropped, next imem_addr is 0x0200 (not 0x0106).
- PC wrap: redirect to 0xFFFE -> fetches 0xFFFE then 0x0000; inst_pc_plus2 for 0xFFFE reads 0x0000.
- Assert rst_n low while in S_WAIT, release, then a late rsp_valid arrives -> inst_valid stays 0; first request issued to RESET_PC.
